// File: rtl/alu_ctrl_pkg.sv
// ID/EX ALU-control package: ALU operation codes, MIPS opcode/funct
// constants and the registered control bundle carried across ID/EX.
package alu_ctrl_pkg;

  // ALU operation codes interpreted by the EX-stage ALU
  localparam logic [5:0] ALUC_ADD = 6'b100000;
  localparam logic [5:0] ALUC_SUB = 6'b100010;
  localparam logic [5:0] ALUC_AND = 6'b100100;
  localparam logic [5:0] ALUC_OR  = 6'b100101;
  localparam logic [5:0] ALUC_XOR = 6'b100110;
  localparam logic [5:0] ALUC_NOR = 6'b100111;
  localparam logic [5:0] ALUC_SLT = 6'b000111;
  localparam logic [5:0] ALUC_SRL = 6'b000000;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Control bundle registered at the ID/EX boundary (immediate kept separate
  // because its width follows DATA_W)
  typedef struct packed {
    logic [5:0] aluc;
    logic       src_a_shamt;
    logic       src_b_imm;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } idex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID/EX stage bus: upstream valid/ready + instruction, flush, downstream
// ready, and the registered ID/EX outputs. The stage is the slave.
interface alu_ctrl_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] instr;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [5:0]        ex_aluc;
  logic              ex_src_a_shamt;
  logic              ex_src_b_imm;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_illegal;
  logic [CNT_W-1:0]  ill_count;

  modport master (
    output id_valid, instr, flush, ex_ready,
    input  id_ready, ex_valid, ex_aluc, ex_src_a_shamt, ex_src_b_imm, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_illegal, ill_count
  );

  modport slave (
    input  id_valid, instr, flush, ex_ready,
    output id_ready, ex_valid, ex_aluc, ex_src_a_shamt, ex_src_b_imm, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_illegal, ill_count
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction decoder producing the ID/EX control bundle
// and the extended immediate.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_instr,
  output idex_ctrl_t        o_ctrl,
  output logic [DATA_W-1:0] o_imm
);

  logic [5:0]        w_op;
  logic [5:0]        w_fn;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;

  assign w_op   = i_instr[31:26];
  assign w_fn   = i_instr[5:0];
  assign w_sext = {{(DATA_W-16){i_instr[15]}}, i_instr[15:0]};
  assign w_zext = {{(DATA_W-16){1'b0}}, i_instr[15:0]};

  // Opcode/funct decode; unknown encodings fall back to an inert ADD marked illegal
  always_comb begin
    o_ctrl      = '0;
    o_imm       = '0;
    o_ctrl.aluc = ALUC_ADD;
    o_ctrl.rs   = i_instr[25:21];
    o_ctrl.rt   = i_instr[20:16];
    if (i_instr != '0) begin
      case (w_op)
        OP_RTYPE: begin
          o_ctrl.rd        = i_instr[15:11];
          o_ctrl.reg_write = 1'b1;
          case (w_fn)
            FN_ADD, FN_ADDU: o_ctrl.aluc = ALUC_ADD;
            FN_SUB, FN_SUBU: o_ctrl.aluc = ALUC_SUB;
            FN_AND:          o_ctrl.aluc = ALUC_AND;
            FN_OR:           o_ctrl.aluc = ALUC_OR;
            FN_XOR:          o_ctrl.aluc = ALUC_XOR;
            FN_NOR:          o_ctrl.aluc = ALUC_NOR;
            FN_SLT:          o_ctrl.aluc = ALUC_SLT;
            FN_SRL: begin
              o_ctrl.aluc        = ALUC_SRL;
              o_ctrl.src_a_shamt = 1'b1;
            end
            default: begin
              o_ctrl.rd        = '0;
              o_ctrl.reg_write = 1'b0;
              o_ctrl.illegal   = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
          o_ctrl.rd        = i_instr[20:16];
          o_ctrl.src_b_imm = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_imm            = w_sext;
          case (w_op)
            OP_SLTI: o_ctrl.aluc = ALUC_SLT;
            OP_ANDI: begin o_ctrl.aluc = ALUC_AND; o_imm = w_zext; end
            OP_ORI:  begin o_ctrl.aluc = ALUC_OR;  o_imm = w_zext; end
            OP_XORI: begin o_ctrl.aluc = ALUC_XOR; o_imm = w_zext; end
            OP_LW:   o_ctrl.mem_read = 1'b1;
            default: o_ctrl.aluc = ALUC_ADD;
          endcase
        end
        OP_SW: begin
          o_ctrl.rd        = i_instr[20:16];
          o_ctrl.src_b_imm = 1'b1;
          o_ctrl.mem_write = 1'b1;
          o_imm            = w_sext;
        end
        OP_BEQ: begin
          o_ctrl.rd     = i_instr[20:16];
          o_ctrl.aluc   = ALUC_SUB;
          o_ctrl.branch = 1'b1;
          o_imm         = w_sext;
        end
        default: o_ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX pipeline register with valid/ready handshake, stall and flush.
// Optional illegal-instruction counter enabled by defining ALU_CTRL_ILLCNT_EN.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  alu_ctrl_stage_if.slave bus
);

  idex_ctrl_t        w_dec;
  logic [DATA_W-1:0] w_dec_imm;
  logic              w_id_ready;
  logic              w_load;

  idex_ctrl_t        r_ctrl;
  logic [DATA_W-1:0] r_imm;
  logic              r_valid;

  alu_ctrl_decode #(.DATA_W(DATA_W)) u_decode (
    .i_instr (bus.instr),
    .o_ctrl  (w_dec),
    .o_imm   (w_dec_imm)
  );

  assign w_id_ready = !r_valid || bus.ex_ready || bus.flush;
  assign w_load     = bus.id_valid && w_id_ready && !bus.flush;

  // ID/EX register: flush and drain clear the whole bundle so an empty stage shows zeros
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_dec;
      r_imm   <= w_dec_imm;
    end else if (bus.ex_ready) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= '0;
    end
  end

`ifdef ALU_CTRL_ILLCNT_EN
  logic [CNT_W-1:0] r_ill_cnt;

  // Saturating count of illegal instructions accepted into the stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ill_cnt <= '0;
    end else if (w_load && w_dec.illegal && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign bus.ill_count = r_ill_cnt;
`else
  assign bus.ill_count = {CNT_W{1'b0}};
`endif

  assign bus.id_ready       = w_id_ready;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_aluc        = r_ctrl.aluc;
  assign bus.ex_src_a_shamt = r_ctrl.src_a_shamt;
  assign bus.ex_src_b_imm   = r_ctrl.src_b_imm;
  assign bus.ex_imm         = r_imm;
  assign bus.ex_rs          = r_ctrl.rs;
  assign bus.ex_rt          = r_ctrl.rt;
  assign bus.ex_rd          = r_ctrl.rd;
  assign bus.ex_reg_write   = r_ctrl.reg_write;
  assign bus.ex_mem_read    = r_ctrl.mem_read;
  assign bus.ex_mem_write   = r_ctrl.mem_write;
  assign bus.ex_branch      = r_ctrl.branch;
  assign bus.ex_illegal     = r_ctrl.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: directed test-plan steps followed by random
// traffic, checked against an instruction-level reference model.
module tb_alu_ctrl_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_ctrl_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();

  alu_ctrl_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [5:0]  aluc;
    logic        sa;
    logic        sb;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } ref_t;

  // Reference model state: which instruction word the stage holds, if any
  logic        m_valid;
  logic [31:0] m_instr;
  logic [15:0] m_cnt;
  logic        m_known;

  int fn_tab [10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 2};
  int op_tab [9]  = '{8, 9, 10, 12, 13, 14, 35, 43, 4};

  function automatic ref_t ref_dec(input logic [31:0] w);
    ref_t e;
    int op;
    int fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    e = '0;
    e.aluc = 6'd32;
    e.rs = w[25:21];
    e.rt = w[20:16];
    if (w == 32'd0) return e;
    if (op == 0) begin
      e.rd = w[15:11];
      e.rw = 1'b1;
      if (fn == 32 || fn == 33) e.aluc = 6'd32;
      else if (fn == 34 || fn == 35) e.aluc = 6'd34;
      else if (fn >= 36 && fn <= 39) e.aluc = 6'(fn);
      else if (fn == 42) e.aluc = 6'd7;
      else if (fn == 2) begin e.aluc = 6'd0; e.sa = 1'b1; end
      else begin e.rd = 5'd0; e.rw = 1'b0; e.ill = 1'b1; end
      return e;
    end
    e.rd = w[20:16];
    case (op)
      8, 9:   begin e.sb = 1; e.rw = 1; e.imm = 32'($signed(w[15:0])); end
      10:     begin e.sb = 1; e.rw = 1; e.aluc = 6'd7; e.imm = 32'($signed(w[15:0])); end
      12:     begin e.sb = 1; e.rw = 1; e.aluc = 6'd36; e.imm = {16'd0, w[15:0]}; end
      13:     begin e.sb = 1; e.rw = 1; e.aluc = 6'd37; e.imm = {16'd0, w[15:0]}; end
      14:     begin e.sb = 1; e.rw = 1; e.aluc = 6'd38; e.imm = {16'd0, w[15:0]}; end
      35:     begin e.sb = 1; e.rw = 1; e.mr = 1; e.imm = 32'($signed(w[15:0])); end
      43:     begin e.sb = 1; e.mw = 1; e.imm = 32'($signed(w[15:0])); end
      4:      begin e.aluc = 6'd34; e.br = 1; e.imm = 32'($signed(w[15:0])); end
      default: begin e.rd = 5'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int unsigned k;
    logic [31:0] w;
    k = $urandom_range(0, 15);
    w = $urandom();
    if (k == 0) return 32'd0;
    if (k <= 5) begin
      w[31:26] = 6'd0;
      w[5:0] = 6'(fn_tab[$urandom_range(0, 9)]);
    end else if (k <= 12) begin
      w[31:26] = 6'(op_tab[$urandom_range(0, 8)]);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check id_ready mid-cycle, advance model, check outputs
  task automatic step(input logic rst_n, input logic v, input logic [31:0] w,
                      input logic f, input logic er);
    ref_t e;
    reset = rst_n;
    bus.id_valid = v;
    bus.instr = w;
    bus.flush = f;
    bus.ex_ready = er;
    #4;
    if (m_known) chk("id_ready", 32'(bus.id_ready), 32'(!m_valid || er || f));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_cnt = 16'd0;
      m_known = 1'b1;
    end else if (f) begin
      m_valid = 1'b0;
    end else if (v && (!m_valid || er)) begin
      m_valid = 1'b1;
      m_instr = w;
`ifdef ALU_CTRL_ILLCNT_EN
      if (ref_dec(w).ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end else if (er) begin
      m_valid = 1'b0;
    end
    #1;
    e = m_valid ? ref_dec(m_instr) : '0;
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("ex_aluc", 32'(bus.ex_aluc), 32'(e.aluc));
    chk("ex_src_a_shamt", 32'(bus.ex_src_a_shamt), 32'(e.sa));
    chk("ex_src_b_imm", 32'(bus.ex_src_b_imm), 32'(e.sb));
    chk("ex_imm", bus.ex_imm, e.imm);
    chk("ex_rs", 32'(bus.ex_rs), 32'(e.rs));
    chk("ex_rt", 32'(bus.ex_rt), 32'(e.rt));
    chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
    chk("ex_ctrl", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch},
        {28'd0, e.rw, e.mr, e.mw, e.br});
    chk("ex_illegal", 32'(bus.ex_illegal), 32'(e.ill));
    chk("ill_count", 32'(bus.ill_count), 32'(m_cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_valid = 1'b0;
    m_instr = '0;
    m_cnt = '0;
    m_known = 1'b0;

    // reset for two cycles
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("reset_id_ready", 32'(bus.id_ready), 32'd1);

    // add, srl, addi -1, andi 0xFFFF
    step(1'b1, 1'b1, 32'h0022_1820, 1'b0, 1'b1);
    chk("add_aluc", 32'(bus.ex_aluc), 32'h20);
    step(1'b1, 1'b1, 32'h0005_20C2, 1'b0, 1'b1);
    chk("srl_shamt", 32'(bus.ex_src_a_shamt), 32'd1);
    step(1'b1, 1'b1, 32'h2002_FFFF, 1'b0, 1'b1);
    chk("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h3002_FFFF, 1'b0, 1'b1);
    chk("andi_imm", bus.ex_imm, 32'h0000_FFFF);

    // stall: lw held three cycles while the next instruction waits
    step(1'b1, 1'b1, 32'h8D28_0004, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'hAD28_0008, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hAD28_0008, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hAD28_0008, 1'b0, 1'b0);
    chk("stall_hold_lw", 32'(bus.ex_mem_read), 32'd1);
    step(1'b1, 1'b1, 32'hAD28_0008, 1'b0, 1'b1);
    chk("stall_release_sw", 32'(bus.ex_mem_write), 32'd1);

    // beq, NOP, flush with incoming instruction, illegal, drain
    step(1'b1, 1'b1, 32'h1109_FFFE, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0022_1820, 1'b1, 1'b0);
    chk("flush_empty", 32'(bus.ex_valid), 32'd0);
    step(1'b1, 1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);
    step(1'b1, 1'b1, 32'hFC00_0000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rnd_instr(),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end

    // mid-stream reset clears everything
    step(1'b1, 1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0022_1820, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
